// File: rtl/texture_cache_fill_pkg.sv
// Shared texture-cache constants and the refill engine state encoding.
package tcache_pkg;

    localparam int TC_LINE_ADDR_W = 39;
    localparam int TC_ENTRY_W     = 296;
    localparam int TC_BEATS       = 4;
    localparam int TC_BEAT_W      = TC_ENTRY_W / TC_BEATS;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        WRITE,
        DRAIN
    } fill_state_e;

endpackage

// File: rtl/texture_cache_fill_if.sv
// Bundle of the miss, memory and cache-write signals of the refill engine.
interface texture_cache_fill_if
    import tcache_pkg::*;
#(
    parameter int ADDR_W = TC_LINE_ADDR_W,
    parameter int DATA_W = TC_ENTRY_W,
    parameter int BEAT_W = TC_BEAT_W
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // sender holds valid and payload stable until then. mem_rsp has no ready.
    logic              except;
    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_ready;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [BEAT_W-1:0] mem_rsp_data;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              write_wen;
    logic              fill_busy;
    fill_state_e       fill_state;

    modport master (
        input  except, miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output miss_ready, mem_req_valid, mem_req_addr, write_addr, write_data, write_wen,
               fill_busy, fill_state
    );

    modport slave (
        output except, miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  miss_ready, mem_req_valid, mem_req_addr, write_addr, write_data, write_wen,
               fill_busy, fill_state
    );

endinterface

// File: rtl/texture_cache_fill_assembler.sv
// Line register bank: each response beat is loaded into its slot, beat 0 at the LSBs.
module tcache_fill_assembler
    import tcache_pkg::*;
#(
    parameter int BEATS  = TC_BEATS,
    parameter int BEAT_W = TC_BEAT_W,
    parameter int CNT_W  = $clog2(BEATS) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [CNT_W-1:0]        idx,
    input  logic [BEAT_W-1:0]       beat,
    output logic [BEATS*BEAT_W-1:0] line
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line <= '0;
        end else if (clear) begin
            line <= '0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (load && int'(idx) == i) begin
                    line[i*BEAT_W +: BEAT_W] <= beat;
                end
            end
        end
    end

endmodule

// File: rtl/texture_cache_fill.sv
// Texture cache refill engine: one memory read per miss, beats assembled into a
// line, then a single-cycle cache write. Repeat misses to the line just filled are dropped.
module texture_cache_fill
    import tcache_pkg::*;
#(
    parameter int ADDR_W = TC_LINE_ADDR_W,
    parameter int DATA_W = TC_ENTRY_W,
    parameter int BEATS  = TC_BEATS
) (
    input  logic                 clk,
    input  logic                 rst,
    texture_cache_fill_if.master bus
);

    localparam int BEAT_W = DATA_W / BEATS;
    localparam int CNT_W  = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ALL_BEATS = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    fill_state_e       state, state_nxt;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              last_vld;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  got;
    logic [DATA_W-1:0] line;
    logic              accept, dedup, req_fire, beat_in;

    assign accept   = bus.miss_valid && state == IDLE && !bus.except;
    assign dedup    = last_vld && bus.miss_addr == last_addr;
    assign req_fire = state == REQ && bus.mem_req_ready;
    assign beat_in  = state == RESP && bus.mem_rsp_valid;
    // Beats received so far, counting one that lands in this very cycle.
    assign got      = beat_cnt + {{(CNT_W-1){1'b0}}, beat_in};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept && !dedup) state_nxt = REQ;
            REQ: begin
                if (req_fire)        state_nxt = bus.except ? DRAIN : RESP;
                else if (bus.except) state_nxt = IDLE;
            end
            RESP: begin
                if (bus.except)                             state_nxt = DRAIN;
                else if (beat_in && beat_cnt == LAST_BEAT) state_nxt = WRITE;
            end
            WRITE: state_nxt = IDLE;
            DRAIN: begin
                if (remaining == '0 || (bus.mem_rsp_valid && remaining == ONE)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            line_addr <= '0;
            last_addr <= '0;
            last_vld  <= 1'b0;
            beat_cnt  <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !dedup) line_addr <= bus.miss_addr;
            if (req_fire)     beat_cnt <= '0;
            else if (beat_in) beat_cnt <= beat_cnt + ONE;
            if (bus.except) begin
                last_vld <= 1'b0;
            end else if (state == WRITE) begin
                last_vld  <= 1'b1;
                last_addr <= line_addr;
            end
            // Beats already requested must still be absorbed after a flush.
            if (req_fire && bus.except) begin
                remaining <= ALL_BEATS;
            end else if (state == RESP && bus.except) begin
                remaining <= ALL_BEATS - got;
            end else if (state == DRAIN && bus.mem_rsp_valid && remaining != '0) begin
                remaining <= remaining - ONE;
            end
        end
    end

    tcache_fill_assembler #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_asm (
        .clk   (clk),
        .rst   (rst),
        .clear (req_fire),
        .load  (beat_in),
        .idx   (beat_cnt),
        .beat  (bus.mem_rsp_data),
        .line  (line)
    );

    assign bus.miss_ready    = state == IDLE;
    assign bus.mem_req_valid = state == REQ;
    assign bus.mem_req_addr  = line_addr;
    assign bus.write_addr    = line_addr;
    assign bus.write_data    = line;
    assign bus.write_wen     = state == WRITE && !bus.except;
    assign bus.fill_busy     = state != IDLE;
    assign bus.fill_state    = state;

    rsp_outside_fill: assert property (@(posedge clk) disable iff (!rst)
        !(bus.mem_rsp_valid && (state == IDLE || state == REQ)));

endmodule
